// File: rtl/booth_multi_hhrb98.sv
// booth_multi_hhrb98: sequential radix-2 Booth multiplier for two signed
// 4-bit operands in the tiny-tile user-project pinout.
//   ui_in[3:0] = multiplicand M, ui_in[7:4] = multiplier Q, uio_in[0] = start.
//   uo_out     = registered signed product, uio_out[7] = done, uio_out[6] = busy.
// Optional build macro BOOTH_DEBUG_EN exposes count and the Booth pair
// {Qreg[0], q_1} on uio_out[5:1].
module booth_multi_hhrb98 #(
   parameter int WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   // The accumulator is one bit wider than the operands so that (-8)x(-8) fits.
   localparam int AW = WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [AW-1:0]     acc;
   logic [AW-1:0]     mreg;
   logic [WIDTH-1:0]  qreg;
   logic              q_1;
   logic [2:0]        count;
   logic [2*WIDTH-1:0] prod;

   logic [AW-1:0]     sum;
   logic [AW-1:0]     acc_sh;
   logic [WIDTH-1:0]  q_sh;
   logic              start;
   logic              done;
   logic              busy;

   assign start = uio_in[0];
   assign done  = (state == DONE);
   assign busy  = (state == RUN);

   // Only uio_in[0] is used; the rest of the bidirectional inputs are ignored.
   logic unused_ok;
   assign unused_ok = &{1'b0, uio_in[7:1]};

   // Next-state logic: launch on start from IDLE/DONE, finish after the last iteration.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_next = state;
      case (state)
         IDLE, DONE: if (start) state_next = RUN;
         RUN:        if (count == 3'd1) state_next = DONE;
         default:    state_next = IDLE;
      endcase
   end

   // One Booth step: conditional add/subtract of Mreg, then arithmetic shift of {A, Qreg, q_1}.
   always_comb begin
      sum = acc;
      case ({qreg[0], q_1})
         2'b01:   sum = acc + mreg;
         2'b10:   sum = acc - mreg;
         default: sum = acc;
      endcase
      acc_sh = {sum[AW-1], sum[AW-1:1]};
      q_sh   = {sum[0], qreg[WIDTH-1:1]};
   end

   // State and datapath registers; reset beats ena, ena=0 freezes everything.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (rst_n) begin
         state <= IDLE;
         acc   <= '0;
         mreg  <= '0;
         qreg  <= '0;
         q_1   <= 1'b0;
         count <= '0;
         prod  <= '0;
      end else if (ena) begin
         state <= state_next;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  mreg  <= {ui_in[WIDTH-1], ui_in[WIDTH-1:0]};
                  qreg  <= ui_in[2*WIDTH-1:WIDTH];
                  acc   <= '0;
                  q_1   <= 1'b0;
                  count <= 3'(WIDTH);
               end
            end
            RUN: begin
               acc   <= acc_sh;
               qreg  <= q_sh;
               q_1   <= qreg[0];
               count <= count - 3'd1;
               // The product is taken from the post-shift values on the final iteration.
               if (count == 3'd1) prod <= {acc_sh[WIDTH-1:0], q_sh};
            end
            default: ;
         endcase
      end
   end

   assign uo_out = prod;

`ifdef BOOTH_DEBUG_EN
   assign uio_out = {done, busy, count, qreg[0], q_1, 1'b0};
   assign uio_oe  = 8'hFE;
`else
   assign uio_out = {done, busy, 6'b0};
   assign uio_oe  = 8'hC0;
`endif

endmodule

// File: tb/tb_booth_multi_hhrb98.sv
// Self-checking bench for booth_multi_hhrb98: table-driven vectors, directed
// latency / restart / reset sequences, and a full 256-value sweep checked
// against a plain signed-multiply reference.
module tb_booth_multi_hhrb98;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_cmp  = 0;
   int n_fail = 0;

   booth_multi_hhrb98 dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uio_in (uio_in),
      .uo_out (uo_out),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] ui;
      logic [7:0] exp;
      bit         stall;
   } vec_t;

   vec_t vecs[$];

   // Reference: signed product of the two nibbles, truncated to 8 bits.
   function automatic logic [7:0] ref_product(input logic [7:0] ui);
      int m;
      int q;
      m = int'($signed(ui[3:0]));
      q = int'($signed(ui[7:4]));
      return 8'(m * q);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock and settle 1 ns past the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch one multiply, optionally freezing with ena=0 for 3 cycles, and wait for done.
   task automatic run_mult(input logic [7:0] ui, input bit stall, output logic [7:0] prod);
      int n;
      ui_in     = ui;
      uio_in[0] = 1'b1;
      step();
      uio_in[0] = 1'b0;
      ui_in     = ~ui;
      if (stall) begin
         step();
         ena = 1'b0;
         repeat (3) step();
         ena = 1'b1;
      end
      n = 0;
      while (!uio_out[7] && n < 20) begin
         step();
         n++;
      end
      if (!uio_out[7]) check("done_timeout", {31'b0, uio_out[7]}, 32'd1);
      prod = uo_out;
   endtask

   initial begin
      logic [7:0] prod;
      logic [7:0] ui;

      rst_n  = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;

      // Reset: held for two cycles, then released.
      repeat (2) step();
      rst_n = 1'b0;
      step();
      check("reset_uo_out", uo_out, 8'h00);
      check("reset_flags", uio_out[7:6], 2'b00);
`ifdef BOOTH_DEBUG_EN
      check("reset_uio_oe", uio_oe, 8'hFE);
`else
      check("reset_uio_oe", uio_oe, 8'hC0);
      check("reset_uio_low", uio_out[5:0], 6'd0);
`endif

      // Latency: start sampled at edge 0, busy after edges 0..3, done after edge 4.
      ui_in     = 8'h23;
      uio_in[0] = 1'b1;
      step();
      uio_in[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("lat_busy_%0d", i), uio_out[7:6], 2'b01);
         check($sformatf("lat_hold_%0d", i), uo_out, 8'h00);
         if (i < 3) step();
      end
      step();
      check("lat_done_flags", uio_out[7:6], 2'b10);
      check("lat_product", uo_out, 8'h06);
      step();
      check("done_stays", uio_out[7:6], 2'b10);

      // Start re-pulsed during RUN and operands changed mid-run.
      ui_in     = 8'h87;
      uio_in[0] = 1'b1;
      step();
      ui_in = 8'h11;
      step();
      uio_in[0] = 1'b0;
      ui_in     = 8'h55;
      step();
      step();
      check("restart_hold_prev", uo_out, 8'h06);
      check("restart_not_done", uio_out[7:6], 2'b01);
      step();
      check("restart_done", uio_out[7:6], 2'b10);
      check("restart_product", uo_out, 8'hC8);

      // Reset in the second RUN cycle aborts the operation.
      ui_in     = 8'h23;
      uio_in[0] = 1'b1;
      step();
      uio_in[0] = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      rst_n = 1'b0;
      check("abort_uo_out", uo_out, 8'h00);
      check("abort_flags", uio_out[7:6], 2'b00);
      run_mult(8'h23, 1'b0, prod);
      check("after_abort_product", prod, 8'h06);

      // Table: directed corners with fixed answers plus random entries from the model.
      vecs.push_back('{ui: 8'h88, exp: 8'h40, stall: 1'b0});
      vecs.push_back('{ui: 8'h87, exp: 8'hC8, stall: 1'b0});
      vecs.push_back('{ui: 8'h1F, exp: 8'hFF, stall: 1'b0});
      vecs.push_back('{ui: 8'h50, exp: 8'h00, stall: 1'b0});
      vecs.push_back('{ui: 8'h23, exp: 8'h06, stall: 1'b1});
      vecs.push_back('{ui: 8'h78, exp: 8'hC8, stall: 1'b1});
      for (int i = 0; i < 10; i++) begin
         ui = 8'($urandom);
         vecs.push_back('{ui: ui, exp: ref_product(ui), stall: bit'($urandom_range(0, 1))});
      end
      foreach (vecs[i]) begin
         run_mult(vecs[i].ui, vecs[i].stall, prod);
         check($sformatf("vec_%0d_ui_%02h", i, vecs[i].ui), prod, vecs[i].exp);
      end

      // Exhaustive sweep, with an ena stall on every 16th operand pair.
      for (int i = 0; i < 256; i++) begin
         ui = 8'(i);
         run_mult(ui, (i % 16) == 5, prod);
         check($sformatf("sweep_%02h", ui), prod, ref_product(ui));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/booth_multi_hhrb98.md
Name: booth_multi_hhrb98

Overview:
- Sequential radix-2 Booth multiplier for two signed 4-bit operands, wrapped in the standard tiny-tile user-project pinout.
- Operands arrive on the dedicated inputs. A pulse or level on a uio input starts a multiply.
- The 8-bit signed product appears on the dedicated outputs, with done and busy flags on uio outputs.
- It is a leaf user project, driven directly by the chip harness.

Parameters:
- WIDTH, 4, operand width in bits (product is 2*WIDTH). Only 4 is supported with this pinout.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  reset. Port name is kept from the harness, but it is synchronous and active-high: 1 = reset, sampled on the clk rising edge.
- ena  input  1  design enable. When 0, all registers hold their value; reset still has priority.
- ui_in  input  8  [3:0] = multiplicand M (signed); [7:4] = multiplier Q (signed).
- uio_in  input  8  [0] = start; [7:1] unused.
- uo_out  output  8  registered signed product P (two's complement).
- uio_out  output  8  [7] = done; [6] = busy; [5:0] = 0 (see Optional Feature).
- uio_oe  output  8  constant 8'hC0.

Behaviour:
- Reset (rst_n=1 at an edge):
  - state=IDLE, P=0, A=0, Qreg=0, q_1=0, count=0.
  - uo_out=0x00, done=0, busy=0.
  - Reset has priority over ena and start; reset during RUN aborts the operation.
- Datapath:
  - A: 5-bit accumulator.
  - Mreg: M sign-extended to 5 bits.
  - Qreg: 4 bits.
  - q_1: 1 bit.
  - count: 3 bits.
- States: IDLE, RUN, DONE.
  - IDLE/DONE with start=1:
    - Load Mreg=sext(ui_in[3:0]), Qreg=ui_in[7:4], A=0, q_1=0, count=4.
    - Go to RUN; done=0.
  - RUN, one iteration per cycle:
    - {Qreg[0],q_1}=01: A=A+Mreg. 10: A=A-Mreg. 00/11: no add.
    - Then arithmetic shift right of {A,Qreg,q_1} by 1 (A[4] replicated).
    - count decrements each iteration.
  - When the 4th iteration completes (count 1 to 0):
    - Go to DONE.
    - Register P={A[3:0],Qreg}, computed from the post-shift values in the same edge.
  - DONE: done=1 and P held. Start=1 restarts exactly as from IDLE; otherwise stay in DONE.
- start handling:
  - start is level-sampled; a held start re-launches every time the FSM returns to DONE.
  - start is ignored while in RUN.
  - Operands are captured only at the start edge; ui_in changes during RUN have no effect.
- Latency:
  - The start-sampling edge is edge 0.
  - Iterations happen at edges 1 to 4.
  - done=1 and the new P are visible after edge 4.
- Flags:
  - busy=1 exactly in RUN.
  - done=1 exactly in DONE.
- Arithmetic:
  - Exact for all 256 operand pairs; product range is -56..64, so there is no overflow.
  - (-8)x(-8)=64 relies on the 5-bit A.
- uo_out holds the previous product throughout RUN and changes only on completion.
- ena=0 mid-RUN freezes the iteration; resuming with ena=1 yields the correct product.

Optional Feature:
- Macro BOOTH_DEBUG_EN.
- When defined:
  - uio_out[5:3]=count.
  - uio_out[2:1]={Qreg[0],q_1}.
  - uio_out[0]=0.
  - uio_oe=8'hFE.
  - uio_in[0] (start) stays an input.
- When undefined: uio_out[5:0]=0 and uio_oe=8'hC0.
- Functional results are identical either way.

Test Plan:
- Reset: assert rst_n=1 for 2 cycles, then release to 0 -> uo_out=0x00, uio_out[7:6]=00, uio_oe=0xC0.
- ui_in=0x23 (M=3, Q=2), start for 1 cycle -> busy=1 for 4 cycles, then done=1, uo_out=0x06 after the 4th edge following start.
- Corners, one run each:
  - ui_in=0x88 -> uo_out=0x40.
  - ui_in=0x87 (M=7, Q=-8) -> uo_out=0xC8.
  - ui_in=0x1F (M=-1, Q=1) -> uo_out=0xFF.
  - ui_in=0x50 -> uo_out=0x00.
- Pulse start again in RUN and change ui_in mid-run -> result still from the original operands; latency unchanged.
- Assert rst_n=1 in cycle 2 of RUN -> next cycle uo_out=0x00, busy=0, done=0; a fresh start with 0x23 -> 0x06.
- Exhaustive sweep of all 256 ui_in values with start; hold ena=0 for 3 cycles mid-run on a subset -> every result matches the signed product M*Q.
